// File: rtl/ttc_trigger_info_reader_pkg.sv
// Shared definitions for the TTC trigger-info word: field positions and widths
// (common to the receiver that packs the word and the reader that unpacks it),
// trigger-type encodings, and the reader FSM state encoding.
package ttc_trigger_info_reader_pkg;

   localparam int WORD_W      = 128;

   localparam int TS_LSB      = 0;
   localparam int TS_W        = 44;
   localparam int TRIGNUM_LSB = 44;
   localparam int TRIGNUM_W   = 24;
   localparam int EVTNUM_LSB  = 68;
   localparam int EVTNUM_W    = 24;
   localparam int TYPE_LSB    = 92;
   localparam int TYPE_W      = 3;
   localparam int EMPTY_BIT   = 95;
   localparam int RSVD_LSB    = 96;
   localparam int RSVD_W      = 32;

   // Trigger-type encodings carried in the type field
   typedef enum logic [TYPE_W-1:0] {
      TRIG_TYPE_NONE     = 3'd0,
      TRIG_TYPE_MUON     = 3'd1,
      TRIG_TYPE_LASER    = 3'd2,
      TRIG_TYPE_PEDESTAL = 3'd3,
      TRIG_TYPE_ASYNC    = 3'd4
   } trig_type_e;

   // One-hot state bit indices, also the encoding seen on the status port
   localparam int ST_IDLE_BIT = 0;
   localparam int ST_HOLD_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b01,
      ST_HOLD = 2'b10
   } state_e;

   typedef struct packed {
      logic [RSVD_W-1:0]    rsvd;
      logic                 empty_event;
      logic [TYPE_W-1:0]    trig_type;
      logic [EVTNUM_W-1:0]  event_num;
      logic [TRIGNUM_W-1:0] trig_num;
      logic [TS_W-1:0]      timestamp;
   } trig_rec_t;

   // Field-by-field unpack, so the layout is tied to the LSB constants above
   function automatic trig_rec_t unpack_word(input logic [WORD_W-1:0] w);
      trig_rec_t r;
      r.rsvd        = w[RSVD_LSB    +: RSVD_W];
      r.empty_event = w[EMPTY_BIT];
      r.trig_type   = w[TYPE_LSB    +: TYPE_W];
      r.event_num   = w[EVTNUM_LSB  +: EVTNUM_W];
      r.trig_num    = w[TRIGNUM_LSB +: TRIGNUM_W];
      r.timestamp   = w[TS_LSB      +: TS_W];
      return r;
   endfunction

endpackage

// File: rtl/ttc_trigger_info_reader_seq_checker.sv
// Trigger-number continuity checker. Tracks the expected trigger number and
// resynchronises to every received value, so one glitched number costs one
// error rather than a cascade.
module ttc_trig_seq_checker
   import ttc_trigger_info_reader_pkg::*;
#(
   parameter bit SEQ_CHECK_EN  = 1'b1,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pop,
   input  logic [TRIGNUM_W-1:0]     trig_num,
   input  logic                     reset_trig_num,
   output logic                     error_seq,
   output logic [ERR_CNT_WIDTH-1:0] seq_err_count
);

   logic [TRIGNUM_W-1:0] exp_num;
   logic                 mismatch;

   // The comparison always uses the registered exp_num, so a same-cycle
   // reset_trig_num only affects the next pop.
   assign mismatch = SEQ_CHECK_EN && (trig_num != exp_num);

   // Expected number: channel-B reset wins over the pop resync
   always_ff @(posedge clk) begin
      if (reset)
         exp_num <= TRIGNUM_W'(1);
      else if (reset_trig_num)
         exp_num <= TRIGNUM_W'(1);
      else if (pop)
         exp_num <= trig_num + TRIGNUM_W'(1);
   end

   // Sticky flag and saturating error count
   always_ff @(posedge clk) begin
      if (reset) begin
         error_seq     <= 1'b0;
         seq_err_count <= '0;
      end else if (pop && mismatch) begin
         error_seq <= 1'b1;
         if (seq_err_count != {ERR_CNT_WIDTH{1'b1}})
            seq_err_count <= seq_err_count + 1'b1;
      end
   end

endmodule

// File: rtl/ttc_trigger_info_reader.sv
// TTC trigger FIFO consumer: pops one 128-bit trigger-info word, holds the
// unpacked record on a valid/ready interface until accepted, and keeps status
// counters and integrity flags.
module ttc_trigger_info_reader
   import ttc_trigger_info_reader_pkg::*;
#(
   parameter bit SEQ_CHECK_EN  = 1'b1,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     reset_trig_num,
   input  logic                     fifo_valid,
   input  logic [WORD_W-1:0]        fifo_data,
   output logic                     fifo_ready,
   output logic                     trig_valid,
   input  logic                     trig_ready,
   output logic                     trig_empty_event,
   output logic [TYPE_W-1:0]        trig_type,
   output logic [EVTNUM_W-1:0]      trig_event_num,
   output logic [TRIGNUM_W-1:0]     trig_num,
   output logic [TS_W-1:0]          trig_timestamp,
   output logic [1:0]               state,
   output logic [31:0]              words_read,
   output logic [31:0]              empty_event_count,
   output logic                     error_seq,
   output logic                     error_reserved,
   output logic [ERR_CNT_WIDTH-1:0] seq_err_count
);

   state_e    state_q;
   trig_rec_t rec;
   logic      pop;

   assign rec   = unpack_word(fifo_data);
   assign pop   = fifo_valid & fifo_ready;
   assign state = state_q;

   // Pop/hold FSM. fifo_ready is registered and only raised in IDLE, so no
   // word can be popped while a record is pending; it stays low for the first
   // cycle after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         fifo_ready       <= 1'b0;
         trig_valid       <= 1'b0;
         trig_empty_event <= 1'b0;
         trig_type        <= '0;
         trig_event_num   <= '0;
         trig_num         <= '0;
         trig_timestamp   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               fifo_ready <= 1'b1;
               if (pop) begin
                  state_q          <= ST_HOLD;
                  fifo_ready       <= 1'b0;
                  trig_valid       <= 1'b1;
                  trig_empty_event <= rec.empty_event;
                  trig_type        <= rec.trig_type;
                  trig_event_num   <= rec.event_num;
                  trig_num         <= rec.trig_num;
                  trig_timestamp   <= rec.timestamp;
               end
            end
            ST_HOLD: begin
               if (trig_valid && trig_ready) begin
                  state_q    <= ST_IDLE;
                  trig_valid <= 1'b0;
                  fifo_ready <= 1'b1;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               fifo_ready <= 1'b0;
               trig_valid <= 1'b0;
            end
         endcase
      end
   end

   // Word counters (wrapping) and reserved-bit sticky flag
   always_ff @(posedge clk) begin
      if (reset) begin
         words_read        <= '0;
         empty_event_count <= '0;
         error_reserved    <= 1'b0;
      end else if (pop) begin
         words_read <= words_read + 32'd1;
         if (rec.empty_event)
            empty_event_count <= empty_event_count + 32'd1;
         if (rec.rsvd != '0)
            error_reserved <= 1'b1;
      end
   end

   ttc_trig_seq_checker #(
      .SEQ_CHECK_EN  (SEQ_CHECK_EN),
      .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
   ) u_seq_checker (
      .clk            (clk),
      .reset          (reset),
      .pop            (pop),
      .trig_num       (rec.trig_num),
      .reset_trig_num (reset_trig_num),
      .error_seq      (error_seq),
      .seq_err_count  (seq_err_count)
   );

endmodule

// File: tb/tb_ttc_trigger_info_reader.sv
// Directed bench for ttc_trigger_info_reader: hand-built words, expected
// record fields, handshake timing, sequence/reserved checks and reset.
module tb_ttc_trigger_info_reader;

   logic         clk;
   logic         reset;
   logic         reset_trig_num;
   logic         fifo_valid;
   logic [127:0] fifo_data;
   logic         fifo_ready;
   logic         trig_valid;
   logic         trig_ready;
   logic         trig_empty_event;
   logic [2:0]   trig_type;
   logic [23:0]  trig_event_num;
   logic [23:0]  trig_num;
   logic [43:0]  trig_timestamp;
   logic [1:0]   state;
   logic [31:0]  words_read;
   logic [31:0]  empty_event_count;
   logic         error_seq;
   logic         error_reserved;
   logic [15:0]  seq_err_count;

   int total = 0;
   int bad   = 0;

   ttc_trigger_info_reader dut (
      .clk               (clk),
      .reset             (reset),
      .reset_trig_num    (reset_trig_num),
      .fifo_valid        (fifo_valid),
      .fifo_data         (fifo_data),
      .fifo_ready        (fifo_ready),
      .trig_valid        (trig_valid),
      .trig_ready        (trig_ready),
      .trig_empty_event  (trig_empty_event),
      .trig_type         (trig_type),
      .trig_event_num    (trig_event_num),
      .trig_num          (trig_num),
      .trig_timestamp    (trig_timestamp),
      .state             (state),
      .words_read        (words_read),
      .empty_event_count (empty_event_count),
      .error_seq         (error_seq),
      .error_reserved    (error_reserved),
      .seq_err_count     (seq_err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] mkword(input logic [31:0] rsvd, input logic empty,
                                           input logic [2:0] typ, input logic [23:0] evt,
                                           input logic [23:0] num, input logic [43:0] ts);
      return {rsvd, empty, typ, evt, num, ts};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a word, wait (bounded) for fifo_ready, pop it, then check the
   // record is valid on the very next cycle.
   task automatic do_pop(input logic [127:0] w, input logic rtn);
      int n;
      n = 0;
      fifo_data  = w;
      fifo_valid = 1'b1;
      while (!fifo_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("pop_wait", 128'(fifo_ready), 128'(1'b1));
      reset_trig_num = rtn;
      @(posedge clk);
      #1;
      fifo_valid     = 1'b0;
      reset_trig_num = 1'b0;
      @(negedge clk);
      chk("lat1_valid", 128'(trig_valid), 128'(1'b1));
   endtask

   // Handshake the pending record and check the block returns to IDLE
   task automatic do_accept();
      logic old;
      old = trig_ready;
      trig_ready = 1'b1;
      @(posedge clk);
      #1;
      trig_ready = old;
      @(negedge clk);
      chk("acc_valid", 128'(trig_valid), 128'(1'b0));
      chk("acc_state", 128'(state), 128'(2'b01));
      chk("acc_ready", 128'(fifo_ready), 128'(1'b1));
   endtask

   task automatic pulse_rtn();
      reset_trig_num = 1'b1;
      @(posedge clk);
      #1;
      reset_trig_num = 1'b0;
   endtask

   task automatic chk_rec(input string tag, input logic [127:0] w);
      chk({tag, "_empty"}, 128'(trig_empty_event), 128'(w[95]));
      chk({tag, "_type"},  128'(trig_type),        128'(w[94:92]));
      chk({tag, "_evt"},   128'(trig_event_num),   128'(w[91:68]));
      chk({tag, "_num"},   128'(trig_num),         128'(w[67:44]));
      chk({tag, "_ts"},    128'(trig_timestamp),   128'(w[43:0]));
   endtask

   logic [127:0] w;
   logic [127:0] w2;

   initial begin
      reset          = 1'b1;
      reset_trig_num = 1'b0;
      fifo_valid     = 1'b0;
      fifo_data      = '0;
      trig_ready     = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 128'(fifo_ready), 128'(1'b0));
      chk("rst_valid", 128'(trig_valid), 128'(1'b0));
      chk("rst_state", 128'(state), 128'(2'b01));
      chk("rst_words", 128'(words_read), 128'(0));
      chk("rst_num",   128'(trig_num), 128'(0));
      chk("rst_err",   128'({error_seq, error_reserved, seq_err_count}), 128'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rel_ready0", 128'(fifo_ready), 128'(1'b0));
      @(negedge clk);
      chk("rel_ready1", 128'(fifo_ready), 128'(1'b1));

      // 1: three in-sequence words, consumer always ready
      trig_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         w = mkword(32'h0, 1'b0, 3'(i), 24'h000100 + 24'(i), 24'(i + 1),
                    44'hA_BCDE_0000_0 + 44'(i * 17));
         do_pop(w, 1'b0);
         chk_rec("t1", w);
         chk("t1_hold_state", 128'(state), 128'(2'b10));
         do_accept();
      end
      chk("t1_words", 128'(words_read), 128'(3));
      chk("t1_eseq", 128'(error_seq), 128'(1'b0));
      trig_ready = 1'b0;

      // 2: consumer stalls with the FIFO still offering the next word
      pulse_rtn();
      w  = mkword(32'h0, 1'b0, 3'd4, 24'h123456, 24'd1, 44'h123_4567_89AB);
      w2 = mkword(32'h0, 1'b0, 3'd1, 24'h654321, 24'd2, 44'hFED_CBA9_8765);
      do_pop(w, 1'b0);
      fifo_data  = w2;
      fifo_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_noready", 128'(fifo_ready), 128'(1'b0));
         chk("t2_stable", 128'({trig_valid, trig_num, trig_timestamp}),
             128'({1'b1, 24'd1, 44'h123_4567_89AB}));
      end
      chk("t2_words_hold", 128'(words_read), 128'(4));
      do_accept();
      do_pop(w2, 1'b0);
      chk_rec("t2b", w2);
      chk("t2_words", 128'(words_read), 128'(5));
      do_accept();

      // 3: gap in the sequence gives exactly one error
      pulse_rtn();
      do_pop(mkword(32'h0, 1'b0, 3'd1, 24'h1, 24'd1, 44'h1), 1'b0);
      chk("t3_eseq0", 128'(error_seq), 128'(1'b0));
      do_accept();
      do_pop(mkword(32'h0, 1'b0, 3'd1, 24'h2, 24'd3, 44'h2), 1'b0);
      chk("t3_eseq1", 128'(error_seq), 128'(1'b1));
      chk("t3_cnt1", 128'(seq_err_count), 128'(1));
      do_accept();
      do_pop(mkword(32'h0, 1'b0, 3'd1, 24'h3, 24'd4, 44'h3), 1'b0);
      chk("t3_cnt_resync", 128'(seq_err_count), 128'(1));
      do_accept();

      // 4: 0xFFFFFF is out of sequence after 4, then the wrap to 0 is clean
      do_pop(mkword(32'h0, 1'b0, 3'd2, 24'h4, 24'hFFFFFF, 44'h4), 1'b0);
      chk("t4_cnt_ff", 128'(seq_err_count), 128'(2));
      do_accept();
      do_pop(mkword(32'h0, 1'b0, 3'd2, 24'h5, 24'h000000, 44'h5), 1'b0);
      chk("t4_wrap", 128'(seq_err_count), 128'(2));
      do_accept();
      pulse_rtn();
      do_pop(mkword(32'h0, 1'b0, 3'd2, 24'h6, 24'd1, 44'h6), 1'b0);
      chk("t4_rtn", 128'(seq_err_count), 128'(2));
      do_accept();
      // reset_trig_num on the pop edge: compare with old expectation (2),
      // then the following word must be 1
      do_pop(mkword(32'h0, 1'b0, 3'd2, 24'h7, 24'd2, 44'h7), 1'b1);
      chk("t4_rtn_same", 128'(seq_err_count), 128'(2));
      do_accept();
      do_pop(mkword(32'h0, 1'b0, 3'd2, 24'h8, 24'd1, 44'h8), 1'b0);
      chk("t4_rtn_after", 128'(seq_err_count), 128'(2));
      do_accept();
      chk("t4_words", 128'(words_read), 128'(13));
      chk("t4_empty0", 128'(empty_event_count), 128'(0));
      chk("t4_rsvd0", 128'(error_reserved), 128'(1'b0));

      // 5: empty event with reserved bits set is still forwarded
      w = mkword(32'hDEADBEEF, 1'b1, 3'd7, 24'hABCDEF, 24'd2, 44'hFFF_FFFF_FFFF);
      do_pop(w, 1'b0);
      chk_rec("t5", w);
      chk("t5_empty_cnt", 128'(empty_event_count), 128'(1));
      chk("t5_rsvd", 128'(error_reserved), 128'(1'b1));
      chk("t5_cnt", 128'(seq_err_count), 128'(2));
      do_accept();

      // 6: reset in the middle of HOLD drops the record and clears status
      do_pop(mkword(32'h0, 1'b0, 3'd3, 24'h9, 24'd3, 44'h9), 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("t6_valid", 128'(trig_valid), 128'(1'b0));
      chk("t6_ready", 128'(fifo_ready), 128'(1'b0));
      chk("t6_state", 128'(state), 128'(2'b01));
      chk("t6_fields", 128'({trig_empty_event, trig_type, trig_event_num, trig_num, trig_timestamp}), 128'(0));
      chk("t6_cnts", 128'({words_read, empty_event_count}), 128'(0));
      chk("t6_flags", 128'({error_seq, error_reserved, seq_err_count}), 128'(0));
      do_pop(mkword(32'h0, 1'b0, 3'd0, 24'hA, 24'd1, 44'hA), 1'b0);
      chk("t6_eseq", 128'(error_seq), 128'(1'b0));
      chk("t6_words", 128'(words_read), 128'(1));
      do_accept();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
